pe_stream_mac: RTL and testbench
================================

# pe_stream_mac

Parametrised streaming multiply-accumulate processing element for the mapping-layer datapath. Each accepted beat carries one pixel sample per channel. The block multiplies each sample by a runtime-loadable per-tap, per-channel signed weight and accumulates over a fixed-length window of TAPS beats. At the end of the window it sums the channels, saturates, and emits one result through a valid/ready output with full backpressure.

## Interface
- CH, 3: channel count (pixel lanes per beat)
- DW, 8: unsigned pixel width per channel
- WW, 8: signed weight width per channel
- TAPS, 6: beats per window (≥2)
- OW, 24: signed output width
- i_clk  in  1  clock, all logic on rising edge
- i_rstn  in  1  reset: one clock; reset is asynchronous and active-low
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid && o_ready
- i_pixel  in  CH*DW  channel c at bits [c*DW +: DW], unsigned
- i_flush  in  1  synchronous abort of the partial window
- i_wr_en  in  1  weight write strobe
- i_wr_addr  in  $clog2(TAPS)  tap index to write
- i_wr_data  in  CH*WW  channel c weight at [c*WW +: WW], signed
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_result  out  OW  signed windowed sum
- o_sat  out  1  result was clamped

## Operation
- Weight store: TAPS×CH registers, reset to 0. Written on i_wr_en regardless of stall. Writes with i_wr_addr ≥ TAPS are ignored. Read at tap_cnt; a same-cycle write to the tap being read returns the old value.
- Pipeline enable `en = !o_valid || i_ready`. `o_ready = en && !i_flush`. All stages and tap_cnt advance only when en is high.
- tap_cnt, 0..TAPS-1: increments on each accepted beat and wraps to 0 after TAPS-1. last = (tap_cnt == TAPS-1).
- S1: p[c] = $signed({1'b0,pixel[c]}) * w[tap_cnt][c], full precision DW+WW+1 bits. Registered with v1 and last1.
- S2: acc[c] = (first ? 0 : acc[c]) + p[c], full precision with no overflow, width DW+WW+1+$clog2(TAPS). first is set by reset, flush, or the S2 update of a last1 beat.
- S3, on v2 && last2: sum = Σ acc[c] at full precision. Clamp to [-2^(OW-1), 2^(OW-1)-1] into o_result. o_sat=1 when clamped. o_valid set.
- o_valid clears on i_ready unless a new result is loaded the same cycle.
- i_flush: clears tap_cnt, v1, v2, and the partial accumulators (first=1). Any beat presented the same cycle is not accepted. The output register is untouched. A completed window already in S2/S3 is dropped only if it has not yet reached the output register.
- Reset mid-operation: all state cleared immediately. Weights are reset to 0.

## Timing
- Reset values: o_valid=0, o_result=0, o_sat=0, o_ready=1 (while i_flush=0).
- Latency: o_valid rises 3 rising edges after the edge accepting the last beat of a window.
- Throughput: 1 beat/clock. Back-to-back windows need no idle cycle.
- Stall: with o_valid=1 and i_ready=0, o_ready=0. o_result, o_sat, and all pipeline state are held stable.
- Simultaneous i_ready and new result: the output register reloads and o_valid stays 1.
- Window boundary and tap_cnt wrap are independent of flush timing. After a flush the next accepted beat is tap 0.

## Configuration
- PE_RELU_EN defined: after saturation, negative results are forced to 0. o_sat still reports clamping performed before the ReLU.
- PE_RELU_EN undefined: the signed result passes through unchanged.

## Test plan
- Defaults, all weights 24'h010101, six beats of i_pixel=24'h010203 → o_result=36, o_sat=0. o_valid appears 3 edges after the 6th beat.
- Weights 24'hFFFFFF (−1), six beats of 24'hFFFFFF → o_result=24'hFFEE12 (−4590). With PE_RELU_EN → 0.
- OW=12, weights 24'h7F7F7F, pixels 24'hFFFFFF ×6 → o_result=2047, o_sat=1.
- Two back-to-back windows with i_ready=0 → the first result is held, and o_ready drops on the stall. Raising i_ready delivers 36 then the second result, with no beat lost.
- Three beats, then i_flush, then six beats of 24'h010203 (weights 1) → a single result of 36.
- Write tap 2 weights during streaming, in the same cycle tap 2 is read → the old weight is used for that beat and the new weight for the next window. Assert i_rstn mid-window → outputs return to reset values immediately.

Source files
------------

// File: rtl/pe_stream_mac.sv
// pe_stream_mac: windowed per-channel signed MAC with saturating valid/ready result output.
// Build option: define PE_RELU_EN to force negative results to zero after saturation.
module pe_stream_mac #(
    parameter int CH   = 3,
    parameter int DW   = 8,
    parameter int WW   = 8,
    parameter int TAPS = 6,
    parameter int OW   = 24
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [CH*DW-1:0]         i_pixel,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [$clog2(TAPS)-1:0]  i_wr_addr,
    input  logic [CH*WW-1:0]         i_wr_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [OW-1:0]     o_result,
    output logic                     o_sat
);
    localparam int TW  = $clog2(TAPS);
    localparam int PW  = DW + WW + 1;
    localparam int AW  = PW + TW;
    localparam int SW0 = AW + $clog2(CH) + 1;
    localparam int SW  = SW0 > OW ? SW0 : OW + 1;
    localparam logic signed [SW-1:0] MAXV = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [WW-1:0] w_q [TAPS][CH];
    logic [TW-1:0]        tap_q;
    logic                 en, accept, last;
    logic signed [PW-1:0] p_d [CH];
    logic signed [PW-1:0] p1_q [CH];
    logic                 v1_q, last1_q;
    logic signed [AW-1:0] acc_q [CH];
    logic                 first_q, v2_q, last2_q;
    logic signed [SW-1:0] sum;
    logic signed [OW-1:0] res_d, r3_q;
    logic                 sat_d, s3_q, v3_q;

    // Weight store; out-of-range tap addresses are dropped, writes ignore stalls.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int t = 0; t < TAPS; t++)
                for (int c = 0; c < CH; c++)
                    w_q[t][c] <= '0;
        end else if (i_wr_en && 32'(i_wr_addr) < TAPS) begin
            for (int c = 0; c < CH; c++)
                w_q[i_wr_addr][c] <= i_wr_data[c*WW +: WW];
        end
    end

    // Handshake enables and stage-1 products from the current tap's weights.
    always_comb begin
        en      = !o_valid || i_ready;
        o_ready = en && !i_flush;
        accept  = i_valid && o_ready;
        last    = tap_q == TW'(TAPS - 1);
        for (int c = 0; c < CH; c++)
            p_d[c] = $signed(PW'({1'b0, i_pixel[c*DW +: DW]})) * PW'(w_q[tap_q][c]);
    end

    // Channel sum of the finished window, clamped to the output range.
    always_comb begin
        sum = '0;
        for (int c = 0; c < CH; c++)
            sum = sum + SW'(acc_q[c]);
        sat_d = sum > MAXV || sum < MINV;
        res_d = sum > MAXV ? OW'(MAXV) : sum < MINV ? OW'(MINV) : OW'(sum);
`ifdef PE_RELU_EN
        res_d = res_d[OW-1] ? '0 : res_d;
`else
        res_d = res_d;
`endif
    end

    // Tap counter and S1..S3 pipeline; flush aborts everything not yet in the output register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tap_q   <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            first_q <= 1'b1;
            v3_q    <= 1'b0;
            r3_q    <= '0;
            s3_q    <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                p1_q[c]  <= '0;
                acc_q[c] <= '0;
            end
        end else if (i_flush) begin
            tap_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            first_q <= 1'b1;
        end else if (en) begin
            if (accept)
                tap_q <= last ? '0 : tap_q + 1'b1;
            v1_q    <= accept;
            last1_q <= accept && last;
            p1_q    <= p_d;
            v2_q    <= v1_q;
            last2_q <= v1_q && last1_q;
            if (v1_q) begin
                first_q <= last1_q;
                for (int c = 0; c < CH; c++)
                    acc_q[c] <= first_q ? AW'(p1_q[c]) : acc_q[c] + AW'(p1_q[c]);
            end
            v3_q <= v2_q && last2_q;
            r3_q <= res_d;
            s3_q <= sat_d;
        end
    end

    // Output register: reloads on a new result, otherwise clears once taken.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid  <= 1'b0;
            o_result <= '0;
            o_sat    <= 1'b0;
        end else if (en && v3_q) begin
            o_valid  <= 1'b1;
            o_result <= r3_q;
            o_sat    <= s3_q;
        end else if (i_ready) begin
            o_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pe_stream_mac.sv
// tb_pe_stream_mac: random and directed stimulus against a window-level reference model.
module tb_pe_stream_mac;
    localparam int TAPS = 6;
    localparam int CH   = 3;
`ifdef PE_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic valid = 1'b0, flush = 1'b0, wr_en = 1'b0, ready = 1'b1;
    logic [23:0] pixel = '0, wr_data = '0;
    logic [2:0]  wr_addr = '0;
    logic o_ready, o_valid, o_sat, o_ready12, o_valid12, o_sat12;
    logic signed [23:0] o_result;
    logic signed [11:0] o_result12;

    int checks = 0;
    int errors = 0;

    longint got24[$], got12[$];
    bit     gots24[$], gots12[$];

    int     mw [TAPS][CH];
    int     mtap;
    longint macc, mres;
    bit     mvalid;
    longint qv[$];
    int     qr[$];

    always #5 clk = ~clk;

    pe_stream_mac dut (
        .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(o_ready), .i_pixel(pixel),
        .i_flush(flush), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_valid(o_valid), .i_ready(ready), .o_result(o_result), .o_sat(o_sat)
    );

    pe_stream_mac #(.OW(12)) dut12 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(o_ready12), .i_pixel(pixel),
        .i_flush(flush), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_valid(o_valid12), .i_ready(ready), .o_result(o_result12), .o_sat(o_sat12)
    );

    function automatic void chk(string nm, logic signed [63:0] act, logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endfunction

    function automatic longint exp_res(longint v, int ow);
        longint mx = (longint'(1) << (ow - 1)) - 1;
        longint mn = -(longint'(1) << (ow - 1));
        longint r = v > mx ? mx : v < mn ? mn : v;
        if (RELU && r < 0) r = 0;
        return r;
    endfunction

    function automatic bit exp_sat(longint v, int ow);
        return v > (longint'(1) << (ow - 1)) - 1 || v < -(longint'(1) << (ow - 1));
    endfunction

    // Reference model: whole-window sums that land in the output after three enabled edges.
    always @(posedge clk) begin
        if (!rstn) begin
            foreach (mw[t, c]) mw[t][c] = 0;
            mtap = 0; macc = 0; mres = 0; mvalid = 0;
            qv.delete(); qr.delete();
        end else begin
            automatic bit men = !mvalid || ready;
            if (men && qr.size() > 0 && qr[0] == 1) begin
                mvalid = 1; mres = qv[0];
                void'(qv.pop_front()); void'(qr.pop_front());
            end else if (ready) mvalid = 0;
            if (flush) begin
                qv.delete(); qr.delete(); macc = 0; mtap = 0;
            end else if (men) begin
                foreach (qr[i]) qr[i]--;
                if (valid) begin
                    for (int c = 0; c < CH; c++) macc += longint'(pixel[c*8 +: 8]) * mw[mtap][c];
                    if (mtap == TAPS - 1) begin
                        qv.push_back(macc); qr.push_back(3); macc = 0; mtap = 0;
                    end else mtap++;
                end
            end
            if (wr_en && wr_addr < TAPS)
                for (int c = 0; c < CH; c++) mw[wr_addr][c] = int'($signed(wr_data[c*8 +: 8]));
        end
    end

    // Per-cycle comparison of both instances against the model, plus delivery log.
    always @(negedge clk) begin
        if (rstn) begin
            chk("o_valid", o_valid, mvalid);
            chk("o_valid12", o_valid12, mvalid);
            chk("o_ready", o_ready, (!mvalid || ready) && !flush);
            if (mvalid) begin
                chk("result24", o_result, exp_res(mres, 24));
                chk("sat24", o_sat, exp_sat(mres, 24));
                chk("result12", o_result12, exp_res(mres, 12));
                chk("sat12", o_sat12, exp_sat(mres, 12));
            end
            if (o_valid && ready) begin
                got24.push_back(o_result); gots24.push_back(o_sat);
                got12.push_back(o_result12); gots12.push_back(o_sat12);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [23:0] px);
        bit ok;
        int n = 0;
        valid = 1'b1; pixel = px;
        do begin
            @(negedge clk); ok = o_ready;
            @(posedge clk); #1; wr_en = 1'b0; n++;
        end while (!ok && n < 200);
        valid = 1'b0;
        chk("send_accepted", ok, 1);
    endtask

    task automatic set_all(input logic [23:0] w);
        for (int t = 0; t < TAPS; t++) begin
            wr_en = 1'b1; wr_addr = 3'(t); wr_data = w; tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic drain();
        ready = 1'b1; valid = 1'b0; flush = 1'b0; wr_en = 1'b0;
        repeat (10) tick();
    endtask

    task automatic clear_log();
        got24.delete(); got12.delete(); gots24.delete(); gots12.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_sat", o_sat, 0);
        chk("rst_ready", o_ready, 1);
        tick(); rstn = 1'b1; tick();

        set_all(24'h010101);
        clear_log();
        repeat (TAPS) send(24'h010203);
        repeat (3) @(negedge clk);
        chk("latency_pre", o_valid, 0);
        @(negedge clk);
        chk("latency_valid", o_valid, 1);
        chk("basic_result", o_result, 36);
        chk("basic_sat", o_sat, 0);
        drain();
        chk("basic_count", got24.size(), 1);

        set_all(24'hFFFFFF);
        clear_log();
        repeat (TAPS) send(24'hFFFFFF);
        drain();
        chk("neg_count", got24.size(), 1);
        chk("neg_result", got24[0], RELU ? 0 : -4590);
        chk("neg_sat", gots24[0], 0);
        chk("neg_result12", got12[0], RELU ? 0 : -2048);
        chk("neg_sat12", gots12[0], 1);

        set_all(24'h7F7F7F);
        clear_log();
        repeat (TAPS) send(24'hFFFFFF);
        drain();
        chk("pos_result12", got12[0], 2047);
        chk("pos_sat12", gots12[0], 1);
        chk("pos_result24", got24[0], 582930);

        set_all(24'h010101);
        clear_log();
        ready = 1'b0;
        repeat (TAPS) send(24'h010203);
        repeat (3) send(24'h030303);
        @(negedge clk);
        chk("stall_valid", o_valid, 1);
        chk("stall_ready", o_ready, 0);
        chk("stall_result", o_result, 36);
        repeat (3) tick();
        @(negedge clk);
        chk("stall_hold", o_result, 36);
        chk("stall_ready_hold", o_ready, 0);
        ready = 1'b1;
        repeat (3) send(24'h030303);
        drain();
        chk("b2b_count", got24.size(), 2);
        chk("b2b_first", got24[0], 36);
        chk("b2b_second", got24[1], 54);

        clear_log();
        repeat (3) send(24'h010203);
        flush = 1'b1; valid = 1'b1; pixel = 24'h010203;
        @(negedge clk);
        chk("flush_blocks_ready", o_ready, 0);
        tick();
        flush = 1'b0; valid = 1'b0;
        repeat (TAPS) send(24'h010203);
        drain();
        chk("flush_count", got24.size(), 1);
        chk("flush_result", got24[0], 36);

        clear_log();
        send(24'h010203); send(24'h010203);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 24'h020202;
        send(24'h010203);
        repeat (3) send(24'h010203);
        repeat (TAPS) send(24'h010203);
        drain();
        chk("wr_count", got24.size(), 2);
        chk("wr_old_weight", got24[0], 36);
        chk("wr_new_weight", got24[1], 42);

        for (int i = 0; i < 3000; i++) begin
            valid   = $urandom_range(0, 3) != 0;
            pixel   = 24'($urandom);
            ready   = $urandom_range(0, 9) < 7;
            flush   = $urandom_range(0, 39) == 0;
            wr_en   = $urandom_range(0, 19) == 0;
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 24'($urandom);
            tick();
        end
        drain();

        ready = 1'b0;
        repeat (TAPS + 2) send(24'h010203);
        repeat (2) tick();
        @(negedge clk);
        chk("pre_reset_valid", o_valid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_valid", o_valid, 0);
        chk("async_rst_result", o_result, 0);
        chk("async_rst_sat", o_sat, 0);
        chk("async_rst_ready", o_ready, 1);
        repeat (2) tick();
        rstn = 1'b1; ready = 1'b1;
        tick();
        clear_log();
        repeat (TAPS) send(24'h010203);
        drain();
        chk("post_rst_count", got24.size(), 1);
        chk("post_rst_zero_weights", got24[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
